// File: rtl/region_stream_reader.sv
// region_stream_reader: read-side initiator for a replicated fifobram region.
// Issues re/raddr/rfifobram requests on one read channel, collects rvalid/rdata
// responses into a small output buffer and presents them as a valid/ready
// stream. Credits (in-flight requests plus buffered words) never exceed the
// buffer depth, so downstream back-pressure cannot cause data loss.
module region_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 5,
  parameter int LOG2_BUF   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [LOG2_DEPTH-1:0] base_addr,
  input  logic [LOG2_DEPTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [LOG2_DEPTH-1:0] raddr,
  output logic [1:0]            rfifobram,
  input  logic                  rvalid,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  empty,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready
);

  localparam int CW  = LOG2_DEPTH + 1;
  localparam int BUF = 2 ** LOG2_BUF;
  localparam logic [1:0] MODE_MEM  = 2'b01;
  localparam logic [1:0] MODE_FIFO = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]       len_q;
  logic [CW-1:0]       issue_cnt;
  logic [CW-1:0]       recv_cnt;
  logic [CW-1:0]       outstanding;

  logic [WIDTH-1:0]    fifo_mem [BUF];
  logic [LOG2_BUF-1:0] wr_ptr;
  logic [LOG2_BUF-1:0] rd_ptr;
  logic [LOG2_BUF:0]   buf_count;

  logic start_go;
  logic cmd_ok;
  logic credit_ok;
  logic issue_start;
  logic issue_run;
  logic re_next;
  logic push;
  logic pop;
  logic drained;

  // outstanding includes the request currently on the bus, because issue_cnt
  // is advanced at the edge that launches re.
  assign outstanding = issue_cnt - recv_cnt;
  assign start_go    = (state == S_IDLE) && start;
  assign cmd_ok      = ((mode == MODE_MEM) || (mode == MODE_FIFO)) && (length != '0);
  assign push        = (state == S_RUN) && rvalid && (outstanding != '0);
  assign out_valid   = (buf_count != '0);
  assign pop         = out_valid && out_ready;
  assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;

  // Pops are ignored here, so the credit estimate is conservative by one word.
  assign credit_ok = ({1'b0, outstanding} + (CW+1)'(buf_count)) < (CW+1)'(BUF);

  // Leave RUN so that DONE lands in the cycle right after the last handshake.
  assign drained = (recv_cnt == len_q) &&
                   ((buf_count == '0) || ((buf_count == (LOG2_BUF+1)'(1)) && pop));

  // First request goes out in the cycle after start; FIFO needs a non-empty source.
  assign issue_start = start_go && cmd_ok && ((mode == MODE_MEM) || !empty);

  // In FIFO mode empty lags a pop by a cycle, so never request back-to-back.
  assign issue_run = (state == S_RUN) && (issue_cnt < len_q) && credit_ok &&
                     ((rfifobram == MODE_MEM) ||
                      ((rfifobram == MODE_FIFO) && !empty && !re));

  assign re_next = issue_start || issue_run;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments on all flops so every register samples pre-edge values.
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = cmd_ok ? S_RUN : S_DONE;
      S_RUN:   if (drained) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM status outputs.
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Command latch, request launch and issue/receive counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      re        <= 1'b0;
      raddr     <= '0;
      rfifobram <= 2'b00;
      len_q     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      re <= re_next;
      if (start_go) begin
        rfifobram <= mode;
        len_q     <= length;
        issue_cnt <= {{(CW-1){1'b0}}, issue_start};
        recv_cnt  <= '0;
        if (mode == MODE_MEM) raddr <= base_addr;
      end else begin
        if (re_next) issue_cnt <= issue_cnt + 1'b1;
        if (push)    recv_cnt  <= recv_cnt + 1'b1;
        // Address wraps naturally at the top of the region.
        if (re && (rfifobram == MODE_MEM)) raddr <= raddr + 1'b1;
      end
    end
  end

  // Output buffer pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 1'b1;
        2'b01:   buf_count <= buf_count - 1'b1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Output buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; out_data is masked to zero while the buffer is empty.
    if (push) fifo_mem[wr_ptr] <= rdata;
  end

endmodule
